microwave_timer_ctrl: RTL and testbench

- Sequencing controller for the microwave countdown timer chain: seconds-units counter, seconds-tens mod-6 counter and minutes counter.
- Generates the chain's load strobe, per-second enable pulses and clear pulse, and runs the cook FSM from the start/stop buttons and the door switch.
- Drives the magnetron enable and the done indication.
- Sits between the keypad/preset logic and the counter chain.

---
 rtl/microwave_timer_ctrl.sv | 153 +++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Cook sequencer for the mm:ss countdown chain: button edge detection,
// one-second prescaler, and the IDLE/RUNNING/PAUSED/DONE FSM with registered strobes.
module microwave_timer_ctrl #(
    parameter int TICK_DIV   = 100,
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       load_req,
    input  logic       count_zero,
    output logic       loadn,
    output logic       en,
    output logic       clrn_cnt,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DONE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] tick_cnt_q, tick_cnt_d;
    logic          loadn_q, loadn_d;
    logic          en_q, en_d;
    logic          clrn_q, clrn_d;
    logic          mag_q, mag_d;
    logic          done_q, done_d;
    logic          startn_q, stopn_q;

    logic          start_ev, stop_ev, tick;
    logic [PW-1:0] presc_inc;

    assign start_ev  = startn_q & ~startn;
    assign stop_ev   = stopn_q & ~stopn;
    assign tick      = (presc_q == PRESC_MAX);
    assign presc_inc = tick ? '0 : presc_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        loadn_d    = 1'b1;
        en_d       = 1'b0;
        clrn_d     = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                presc_d    = '0;
                tick_cnt_d = '0;
                // Clear beats load beats start so the three strobes stay exclusive.
                if (stop_ev)
                    clrn_d = 1'b0;
                else if (load_req)
                    loadn_d = 1'b0;
                else if (start_ev && door_closed && !count_zero)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!door_closed || stop_ev) begin
                    state_d = ST_PAUSE;
                end else if (count_zero) begin
                    state_d    = ST_DONE;
                    presc_d    = '0;
                    tick_cnt_d = '0;
                end else begin
                    presc_d = presc_inc;
                    en_d    = tick;
                end
            end
            ST_PAUSE: begin
                // Prescaler is deliberately held so a resumed cook keeps its phase.
                if (stop_ev) begin
                    state_d = ST_IDLE;
                    clrn_d  = 1'b0;
                end else if (load_req) begin
                    loadn_d = 1'b0;
                end else if (start_ev && door_closed) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop_ev || !door_closed) begin
                    state_d = ST_IDLE;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        if (tick_cnt_q == DONE_LAST) begin
                            state_d    = ST_IDLE;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_cnt_q + DW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mag_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            loadn_q    <= 1'b1;
            en_q       <= 1'b0;
            clrn_q     <= 1'b1;
            mag_q      <= 1'b0;
            done_q     <= 1'b0;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            loadn_q    <= loadn_d;
            en_q       <= en_d;
            clrn_q     <= clrn_d;
            mag_q      <= mag_d;
            done_q     <= done_d;
            startn_q   <= startn;
            stopn_q    <= stopn;
        end
    end

    assign loadn    = loadn_q;
    assign en       = en_q;
    assign clrn_cnt = clrn_q;
    assign mag_on   = mag_q;
    assign done     = done_q;
    assign state    = state_q;

    a_en_only_running: assert property (@(posedge clk) disable iff (clr)
        !(en_q && state_q != ST_RUN));
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (clr)
        $onehot0({~loadn_q, en_q, ~clrn_q}));

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with a BCD mm:ss down-counter model
// driven by the controller's loadn/en/clrn_cnt strobes.
module tb_microwave_timer_ctrl;

    logic        clk = 1'b0;
    logic        clr, startn, stopn, door_closed, load_req, count_zero;
    logic        loadn, en, clrn_cnt, mag_on, done;
    logic [1:0]  state;
    logic [11:0] preset;
    logic [3:0]  mi = 4'd0, st = 4'd0, su = 4'd0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    microwave_timer_ctrl #(.TICK_DIV(4), .DONE_TICKS(2)) dut (
        .clk(clk), .clr(clr), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .load_req(load_req), .count_zero(count_zero),
        .loadn(loadn), .en(en), .clrn_cnt(clrn_cnt), .mag_on(mag_on),
        .done(done), .state(state)
    );

    assign count_zero = (mi == 4'd0) && (st == 4'd0) && (su == 4'd0);

    // Counter chain model: clear > load > decrement.
    always @(posedge clk) begin
        if (!clrn_cnt) begin
            mi <= 4'd0; st <= 4'd0; su <= 4'd0;
        end else if (!loadn) begin
            mi <= preset[11:8]; st <= preset[7:4]; su <= preset[3:0];
        end else if (en) begin
            if (su != 4'd0) su <= su - 4'd1;
            else if (st != 4'd0) begin su <= 4'd9; st <= st - 4'd1; end
            else if (mi != 4'd0) begin su <= 4'd9; st <= 4'd5; mi <= mi - 4'd1; end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [11:0] p);
        preset   = p;
        load_req = 1'b1;
        step();
        chk("load_loadn_low", loadn, 1'b0);
        load_req = 1'b0;
        step();
        chk("load_loadn_high", loadn, 1'b1);
    endtask

    task automatic press_start();
        startn = 1'b0;
        step();
        startn = 1'b1;
    endtask

    initial begin
        int cnt;
        clr = 1'b1; startn = 1'b0; stopn = 1'b0; door_closed = 1'b1;
        load_req = 1'b0; preset = 12'h000;

        // Reset with buttons held low, release together with clr
        step(2);
        chk("rst_state", state, 2'b00);
        chk("rst_loadn", loadn, 1'b1);
        chk("rst_en", en, 1'b0);
        chk("rst_clrn", clrn_cnt, 1'b1);
        chk("rst_mag", mag_on, 1'b0);
        chk("rst_done", done, 1'b0);
        clr = 1'b0; startn = 1'b1; stopn = 1'b1;
        step();
        chk("post_rst_state", state, 2'b00);
        chk("post_rst_clrn", clrn_cnt, 1'b1);

        // Start rejected while the chain reads 00:00
        press_start();
        chk("rej_zero_state", state, 2'b00);
        chk("rej_zero_mag", mag_on, 1'b0);

        // Full cook of 00:03
        load(12'h003);
        press_start();
        chk("cook_state", state, 2'b01);
        chk("cook_mag", mag_on, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("cook_en", en, ((k % 4) == 0));
        end
        chk("cook_state_e13", state, 2'b01);
        step();
        chk("done_state", state, 2'b11);
        chk("done_out", done, 1'b1);
        chk("done_mag", mag_on, 1'b0);
        cnt = 1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (done) cnt++;
        end
        chk("done_cycles", cnt, 8);
        step();
        chk("done_exit_state", state, 2'b00);
        chk("done_exit_done", done, 1'b0);

        // Start rejected with door open
        load(12'h005);
        door_closed = 1'b0;
        press_start();
        chk("rej_door_state", state, 2'b00);
        chk("rej_door_mag", mag_on, 1'b0);
        door_closed = 1'b1;
        step();

        // Door opens mid-run with the prescaler at 2, resume keeps the phase
        press_start();
        chk("pause_run_state", state, 2'b01);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("pause_run_en", en, (k == 4));
        end
        door_closed = 1'b0;
        step();
        chk("pause_state", state, 2'b10);
        chk("pause_mag", mag_on, 1'b0);
        chk("pause_en", en, 1'b0);
        cnt = 0;
        repeat (3) begin step(); if (en) cnt++; end
        chk("pause_no_en", cnt, 0);
        door_closed = 1'b1;
        load(12'h005);
        chk("pause_load_state", state, 2'b10);
        press_start();
        chk("resume_state", state, 2'b01);
        chk("resume_mag", mag_on, 1'b1);
        step();
        chk("resume_en_1", en, 1'b0);
        step();
        chk("resume_en_2", en, 1'b1);

        // Stop pauses a run, second stop cancels with a clear pulse
        stopn = 1'b0;
        step();
        chk("stop_run_state", state, 2'b10);
        chk("stop_run_en", en, 1'b0);
        stopn = 1'b1;
        step();
        stopn = 1'b0;
        step();
        chk("cancel_state", state, 2'b00);
        chk("cancel_clrn", clrn_cnt, 1'b0);
        stopn = 1'b1;
        step();
        chk("cancel_clrn_end", clrn_cnt, 1'b1);

        // Stop held in IDLE gives exactly one clear pulse
        stopn = 1'b0;
        step();
        chk("idle_stop_clrn", clrn_cnt, 1'b0);
        chk("idle_stop_state", state, 2'b00);
        cnt = 0;
        repeat (9) begin step(); if (!clrn_cnt) cnt++; end
        chk("stop_held_pulses", cnt, 0);
        stopn = 1'b1;
        step();

        // Load and start in the same cycle: load wins, start dropped
        preset = 12'h005; load_req = 1'b1; startn = 1'b0;
        step();
        chk("ld_st_loadn", loadn, 1'b0);
        chk("ld_st_state", state, 2'b00);
        load_req = 1'b0; startn = 1'b1;
        step();
        chk("ld_st_dropped", state, 2'b00);

        // clr mid-run after the first en, then prescaler restarts from 0
        press_start();
        chk("clr_run_state", state, 2'b01);
        step(4);
        chk("clr_run_en", en, 1'b1);
        step();
        clr = 1'b1;
        step();
        chk("clr_state", state, 2'b00);
        chk("clr_mag", mag_on, 1'b0);
        chk("clr_en", en, 1'b0);
        chk("clr_loadn", loadn, 1'b1);
        chk("clr_clrn", clrn_cnt, 1'b1);
        chk("clr_done", done, 1'b0);
        clr = 1'b0;
        press_start();
        chk("restart_state", state, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("restart_en", en, (k == 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
